// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: decoded instruction in, writeback port, ID/EX outputs.
interface alu_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            valid_i;
  logic            stall_i;
  logic            flush_i;
  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic [XLEN-1:0] imm_i;
  logic            use_imm_i;
  logic [1:0]      alu_op_i;
  logic [AW-1:0]   rd_addr_i;
  logic            rd_we_i;
  logic            wb_we_i;
  logic [AW-1:0]   wb_addr_i;
  logic [XLEN-1:0] wb_data_i;
  logic [XLEN-1:0] data1_o;
  logic [XLEN-1:0] data2_o;
  logic [1:0]      AluOp_o;
  logic [AW-1:0]   rd_addr_o;
  logic            rd_we_o;
  logic            valid_o;

  modport master (
    output valid_i, stall_i, flush_i,
    output rs1_addr_i, rs2_addr_i,
    output imm_i, use_imm_i, alu_op_i,
    output rd_addr_i, rd_we_i,
    output wb_we_i, wb_addr_i, wb_data_i,
    input  data1_o, data2_o, AluOp_o,
    input  rd_addr_o, rd_we_o, valid_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i,
    input  rs1_addr_i, rs2_addr_i,
    input  imm_i, use_imm_i, alu_op_i,
    input  rd_addr_i, rd_we_i,
    input  wb_we_i, wb_addr_i, wb_data_i,
    output data1_o, data2_o, AluOp_o,
    output rd_addr_o, rd_we_o, valid_o
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand fetch: 32x32 register file, operand select and ID/EX register.
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input logic               clk_i,
  input logic               rst_ni,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            rd_we;
    logic [AW-1:0]   rd_addr;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
  } id_ex_t;

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op2;
  logic            wb_hit;
  id_ex_t          q;
  id_ex_t          d;

  assign wb_hit = bus.wb_we_i
               && (bus.wb_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 1; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wb_hit) begin
      regs[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  // Write-first: a same-cycle writeback is visible to the read.
  always_comb begin
    rs1_val = '0;
    if (bus.rs1_addr_i != '0) begin
      if (wb_hit && bus.wb_addr_i == bus.rs1_addr_i)
        rs1_val = bus.wb_data_i;
      else
        rs1_val = regs[bus.rs1_addr_i];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (bus.rs2_addr_i != '0) begin
      if (wb_hit && bus.wb_addr_i == bus.rs2_addr_i)
        rs2_val = bus.wb_data_i;
      else
        rs2_val = regs[bus.rs2_addr_i];
    end
  end

  assign op2 = bus.use_imm_i ? bus.imm_i
                             : rs2_val;

  always_comb begin
    d = q;
    if (bus.flush_i) begin
      d = '0;
    end else if (!bus.stall_i) begin
      d = '0;
      if (bus.valid_i) begin
        d.valid   = 1'b1;
        d.rd_we   = bus.rd_we_i;
        d.rd_addr = bus.rd_addr_i;
        d.alu_op  = bus.alu_op_i;
        d.data1   = rs1_val;
        d.data2   = op2;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      q <= '0;
    else
      q <= d;
  end

  assign bus.data1_o   = q.data1;
  assign bus.data2_o   = q.data2;
  assign bus.AluOp_o   = q.alu_op;
  assign bus.rd_addr_o = q.rd_addr;
  assign bus.rd_we_o   = q.rd_we;
  assign bus.valid_o   = q.valid;

endmodule
